// File: rtl/activation_pipe.sv
// Two-stage activation pipeline: double-width signed accumulator in, activated and
// saturated single-width result out, with a sticky saturation event counter.
module activation_pipe #(
    parameter int data_width = 16,
    parameter int leak_shift = 3,
    parameter int cap        = 6144,
    parameter int cnt_width  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2*data_width-1:0]   in_data,
    input  logic [1:0]                in_mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [data_width-1:0]     out_data,
    output logic                      out_sat,
    input  logic                      cnt_clr,
    output logic [cnt_width-1:0]      sat_count,
    output logic [1:0]                stage_state
);

    localparam int xw = 2 * data_width;

    localparam logic [data_width-1:0] max_val = {1'b0, {(data_width-1){1'b1}}};
    localparam logic [data_width-1:0] min_val = {1'b1, {(data_width-1){1'b0}}};
    localparam logic [data_width-1:0] cap_val = data_width'(cap);
    localparam logic signed [xw-1:0]  cap_ext = xw'(cap);

    // Result source chosen in the first stage; the second stage only muxes.
    typedef enum logic [2:0] {
        sel_x    = 3'd0,
        sel_y    = 3'd1,
        sel_zero = 3'd2,
        sel_max  = 3'd3,
        sel_min  = 3'd4,
        sel_cap  = 3'd5
    } sel_t;

    // Handshake: a beat moves on a rising edge where valid && ready are both high;
    // valid never waits on ready, and data/sat are held stable while valid && !ready.
    logic s1_valid;
    logic s2_load;
    logic in_fire;

    assign s2_load     = !out_valid || out_ready;
    assign in_ready    = !s1_valid || s2_load;
    assign in_fire     = in_valid && in_ready;
    assign stage_state = {s1_valid, out_valid};

    logic                   x_neg;
    logic                   x_over;
    logic                   x_under;
    logic                   x_over_cap;
    logic                   y_under;
    logic signed [xw-1:0]   x_signed;
    logic signed [xw-1:0]   shifted;

    assign x_signed   = $signed(in_data);
    assign x_neg      = in_data[xw-1];
    assign x_over     = !x_neg && (|in_data[xw-2:data_width-1]);
    assign x_under    = x_neg && !(&in_data[xw-2:data_width-1]);
    assign x_over_cap = !x_neg && (x_signed > cap_ext);
    assign shifted    = x_signed >>> leak_shift;
    // Only consulted for negative inputs, where the shifted value stays negative.
    assign y_under    = !(&shifted[xw-1:data_width-1]);

    sel_t dec_sel;
    logic dec_sat;

    always_comb begin
        dec_sel = sel_x;
        dec_sat = 1'b0;
        case (in_mode)
            2'd0: begin
                if (x_neg) begin
                    dec_sel = sel_zero;
                end else if (x_over) begin
                    dec_sel = sel_max;
                    dec_sat = 1'b1;
                end
            end
            2'd1: begin
                if (x_neg) begin
                    if (y_under) begin
                        dec_sel = sel_min;
                        dec_sat = 1'b1;
                    end else begin
                        dec_sel = sel_y;
                    end
                end else if (x_over) begin
                    dec_sel = sel_max;
                    dec_sat = 1'b1;
                end
            end
            2'd2: begin
                if (x_over) begin
                    dec_sel = sel_max;
                    dec_sat = 1'b1;
                end else if (x_under) begin
                    dec_sel = sel_min;
                    dec_sat = 1'b1;
                end
            end
            default: begin
                if (x_neg) begin
                    dec_sel = sel_zero;
                end else if (x_over_cap) begin
                    dec_sel = sel_cap;
                    dec_sat = 1'b1;
                end
            end
        endcase
    end

    sel_t                  s1_sel;
    logic                  s1_sat;
    logic [data_width-1:0] s1_x_low;
    logic [data_width-1:0] s1_y_low;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sel   <= sel_x;
            s1_sat   <= 1'b0;
            s1_x_low <= '0;
            s1_y_low <= '0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_sel   <= dec_sel;
                s1_sat   <= dec_sat;
                s1_x_low <= in_data[data_width-1:0];
                s1_y_low <= shifted[data_width-1:0];
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    logic [data_width-1:0] res_data;

    always_comb begin
        res_data = s1_x_low;
        case (s1_sel)
            sel_y:    res_data = s1_y_low;
            sel_zero: res_data = '0;
            sel_max:  res_data = max_val;
            sel_min:  res_data = min_val;
            sel_cap:  res_data = cap_val;
            default:  res_data = s1_x_low;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= res_data;
                out_sat  <= s1_sat;
            end
        end
    end

    // Clear takes priority; the count sticks once it reaches all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (cnt_clr) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && out_sat && !(&sat_count)) begin
            sat_count <= sat_count + cnt_width'(1);
        end
    end

endmodule

// File: tb/tb_activation_pipe.sv
// Randomized and directed bench for activation_pipe, scored against an arithmetic
// model of the activation rules; a second instance exercises a 2-bit counter.
module tb_activation_pipe;

    localparam int dw   = 16;
    localparam int xw   = 32;
    localparam int leak = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic [xw-1:0] in_data = '0;
    logic [1:0]    in_mode = '0;
    logic          out_ready = 1'b1;
    logic          cnt_clr = 1'b0;

    logic          in_ready, out_valid, out_sat;
    logic [dw-1:0] out_data;
    logic [15:0]   sat_count;
    logic [1:0]    stage_state;

    logic          in_ready_s, out_valid_s, out_sat_s;
    logic [dw-1:0] out_data_s;
    logic [1:0]    sat_count_s;
    logic [1:0]    stage_state_s;

    activation_pipe #(.data_width(dw), .leak_shift(leak), .cap(6144), .cnt_width(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat), .cnt_clr(cnt_clr), .sat_count(sat_count),
        .stage_state(stage_state)
    );

    activation_pipe #(.data_width(dw), .leak_shift(leak), .cap(6144), .cnt_width(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data(out_data_s), .out_sat(out_sat_s), .cnt_clr(cnt_clr), .sat_count(sat_count_s),
        .stage_state(stage_state_s)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model
    function automatic logic [dw:0] ref_act(input logic [xw-1:0] raw, input logic [1:0] mode);
        longint x, y, d, r;
        longint mx, mn, cp;
        logic   sat;
        mx  = 32767;
        mn  = -32768;
        cp  = 6144;
        d   = longint'(1) << leak;
        x   = longint'($signed(raw));
        sat = 1'b0;
        r   = x;
        case (mode)
            2'd0: begin
                if (x < 0) r = 0;
                else if (x > mx) begin r = mx; sat = 1'b1; end
            end
            2'd1: begin
                if (x < 0) begin
                    y = -((-x + d - 1) / d);
                    if (y < mn) begin r = mn; sat = 1'b1; end
                    else r = y;
                end else if (x > mx) begin r = mx; sat = 1'b1; end
            end
            2'd2: begin
                if (x > mx) begin r = mx; sat = 1'b1; end
                else if (x < mn) begin r = mn; sat = 1'b1; end
            end
            default: begin
                if (x < 0) r = 0;
                else if (x > cp) begin r = cp; sat = 1'b1; end
            end
        endcase
        return {sat, r[dw-1:0]};
    endfunction

    // scoreboard state
    logic [dw:0]      exp_q[$];
    logic [xw+1:0]    stim_q[$];
    int               exp_cnt = 0;
    int               exp_cnt_s = 0;
    int               accepts = 0;
    logic             took = 1'b0;
    logic             held_valid = 1'b0;
    logic [dw:0]      held = '0;
    int               vprob = 100;
    logic             rand_ready = 1'b0;
    logic             rand_clr = 1'b0;

    // driver: holds a beat until it is taken
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            in_valid = 1'b0;
        end else begin
            if (took && stim_q.size() > 0) void'(stim_q.pop_front());
            if (in_valid && !took && stim_q.size() > 0) begin
                {in_mode, in_data} = stim_q[0];
            end else if (stim_q.size() > 0 && $urandom_range(1, 100) <= vprob) begin
                in_valid = 1'b1;
                {in_mode, in_data} = stim_q[0];
            end else begin
                in_valid = 1'b0;
                in_data  = $urandom;
                in_mode  = 2'($urandom_range(0, 3));
            end
        end
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        if (rand_clr) cnt_clr = ($urandom_range(0, 31) == 0);
    end

    // monitor: sampled on the falling edge
    always @(negedge clk) begin
        logic [dw:0] e;
        if (!rst_n) begin
            took       = 1'b0;
            held_valid = 1'b0;
        end else begin
            check("sat_count", 32'(sat_count), 32'(exp_cnt));
            check("sat_count_w2", 32'(sat_count_s), 32'(exp_cnt_s));
            if (held_valid && out_valid) check("stall_hold", 32'({out_sat, out_data}), 32'(held));
            e = '0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out", 32'({out_sat, out_data}), 32'(e));
                end
            end
            took = in_valid && in_ready;
            if (took) begin
                exp_q.push_back(ref_act(in_data, in_mode));
                accepts++;
            end
            if (cnt_clr) begin
                exp_cnt   = 0;
                exp_cnt_s = 0;
            end else if (out_valid && out_ready && e[dw]) begin
                if (exp_cnt < 65535) exp_cnt++;
                if (exp_cnt_s < 3) exp_cnt_s++;
            end
            held_valid = out_valid && !out_ready;
            held       = {out_sat, out_data};
        end
    end

    task automatic push(input logic [1:0] m, input logic [xw-1:0] d);
        stim_q.push_back({m, d});
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0 || in_valid) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", 32'(n < 3000), 32'd1);
        @(posedge clk);
        #2;
    endtask

    task automatic one_shot(input logic [1:0] m, input logic [xw-1:0] d);
        logic [dw:0] e;
        e = ref_act(d, m);
        @(posedge clk); #2;
        push(m, d);
        @(posedge clk);
        @(posedge clk); #2;
        check("lat_s1_only", 32'(out_valid), 32'd0);
        @(posedge clk); #2;
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_data", 32'({out_sat, out_data}), 32'(e));
    endtask

    function automatic logic [xw-1:0] rand_data();
        logic [xw-1:0] edges[12];
        edges = '{32'h0000_7FFF, 32'h0000_8000, 32'hFFFF_8000, 32'hFFFF_7FFF,
                  32'h0000_1800, 32'h0000_1801, 32'h0000_17FF, 32'h0000_0000,
                  32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFB_FFFF};
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return xw'($urandom_range(0, 32'h4_0000)) - 32'h2_0000;
            2: return edges[$urandom_range(0, 11)];
            default: return xw'($urandom_range(0, 32'h1_0000)) - 32'h8000;
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int n;
        // reset seen before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sat", 32'(out_sat), 32'd0);
        check("rst_sat_count", 32'(sat_count), 32'd0);
        check("rst_state", 32'(stage_state), 32'd0);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;

        // directed vectors with latency
        one_shot(2'd0, 32'h0000_4000);
        one_shot(2'd0, 32'h0000_8000);
        one_shot(2'd0, 32'hFFFF_F000);
        one_shot(2'd1, 32'hFFFF_FFC0);
        one_shot(2'd1, 32'h8000_0000);
        one_shot(2'd1, 32'h0001_0000);
        one_shot(2'd2, 32'h7FFF_FFFF);
        one_shot(2'd2, 32'hFFFF_8000);
        one_shot(2'd3, 32'h0000_2000);
        one_shot(2'd3, 32'h0000_1000);
        wait_drain();

        // backpressure: five beats, alternating modes, stalled 4 cycles
        out_ready = 1'b0;
        a0 = accepts;
        push(2'd0, 32'hFFFF_FFC0);
        push(2'd1, 32'hFFFF_FFC0);
        push(2'd2, 32'h0001_0000);
        push(2'd3, 32'h0000_2000);
        push(2'd1, 32'h8000_0000);
        repeat (4) @(posedge clk);
        #2;
        check("bp_accepted", 32'(accepts - a0), 32'd2);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_comb", 32'(in_ready), 32'd1);
        wait_drain();

        // counter
        cnt_clr = 1'b1;
        @(posedge clk); #2;
        cnt_clr = 1'b0;
        repeat (3) push(2'd0, 32'h0000_8000);
        wait_drain();
        check("cnt_three", 32'(sat_count), 32'd3);
        check("cnt_three_w2", 32'(sat_count_s), 32'd3);
        out_ready = 1'b0;
        push(2'd2, 32'h7FFF_FFFF);
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #2; n++; end
        check("cnt_fourth_ready", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        cnt_clr = 1'b1;
        @(posedge clk); #2;
        cnt_clr = 1'b0;
        check("cnt_clr_wins", 32'(sat_count), 32'd0);
        repeat (5) push(2'd3, 32'h0000_2000);
        wait_drain();
        check("cnt_five", 32'(sat_count), 32'd5);
        check("cnt_stick_w2", 32'(sat_count_s), 32'd3);

        // randomized traffic
        vprob = 70;
        rand_ready = 1'b1;
        rand_clr = 1'b1;
        for (int i = 0; i < 400; i++) push(2'($urandom_range(0, 3)), rand_data());
        wait_drain();
        rand_ready = 1'b0;
        rand_clr = 1'b0;
        #1;
        out_ready = 1'b1;
        cnt_clr = 1'b0;
        vprob = 100;
        @(posedge clk); #2;

        // asynchronous reset with two beats in flight
        out_ready = 1'b0;
        push(2'd0, 32'h0000_4000);
        push(2'd1, 32'hFFFF_FFC0);
        n = 0;
        while (stage_state != 2'b11 && n < 20) begin @(posedge clk); #2; n++; end
        check("rst_fill", 32'(stage_state), 32'd3);
        @(posedge clk); #3;
        rst_n = 1'b0;
        stim_q.delete();
        exp_q.delete();
        exp_cnt = 0;
        exp_cnt_s = 0;
        in_valid = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_state", 32'(stage_state), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_data", 32'(out_data), 32'd0);
        check("arst_sat_count", 32'(sat_count), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #2;
            check("no_stale", 32'(out_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/activation_pipe.md
# activation_pipe

Pipelined, parametrised activation stage for the neuron datapath. Accepts one double-width signed accumulator value per beat over a valid/ready handshake, applies a per-beat-selectable activation function (ReLU, leaky ReLU, signed saturate, capped ReLU), saturates to the single-width output format and flags the clip. Sits between a neuron's MAC accumulator and the next layer's input buffer, and keeps a saturation event counter for overflow monitoring.

## Interface
- `data_width`, 16: output width in bits; the input is `2*data_width`, signed two's complement, same binary-point scale as the output.
- `leak_shift`, 3: arithmetic right shift applied to negative inputs in leaky mode (slope 2^-leak_shift); range 1..data_width.
- `cap`, 6144: upper clamp for capped mode (6.0 at 10 fractional bits); must lie in 0..2^(data_width-1)-1.
- `cnt_width`, 16: width of the saturation counter.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  stage can accept an input beat.
- `in_data`  in  2*data_width  signed accumulator value.
- `in_mode`  in  2  activation select, sampled with the beat: 0 ReLU, 1 leaky ReLU, 2 signed saturate, 3 capped ReLU.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accepts output.
- `out_data`  out  data_width  activated, saturated result.
- `out_sat`  out  1  result was clipped, travels with `out_data`.
- `cnt_clr`  in  1  synchronous clear of `sat_count`.
- `sat_count`  out  cnt_width  saturating count of transferred beats with `out_sat`=1.

## Operation
- Let MAX = 2^(data_width-1)-1, MIN = -2^(data_width-1), x = signed `in_data`.
- Mode 0 ReLU: x<0 -> 0, sat=0; 0<=x<=MAX -> x; x>MAX -> MAX, sat=1. Overflow test covers all bits from the sign bit down to bit data_width-1, so x = 2^(data_width-1) saturates.
- Mode 1 leaky: x>=0 as mode 0; x<0 -> y = x >>> leak_shift (rounds toward -inf); y<MIN -> MIN, sat=1; else y, sat=0.
- Mode 2 signed saturate: x>MAX -> MAX, sat=1; x<MIN -> MIN, sat=1; else x.
- Mode 3 capped: x<0 -> 0, sat=0; x>cap -> cap, sat=1; else x.
- Two register stages: S1 registers mode-decoded compare/shift results; S2 registers `out_data`/`out_sat`/`out_valid`. Each stage holds a valid bit.
- Flow control: S2 loads when empty or `out_ready`=1; S1 advances into S2 under the same condition; `in_ready` = !S1.valid || S2 can load. Beats never dropped, duplicated or reordered; mode is carried per beat, so mode changes between beats take effect exactly at the beat boundary.
- Counter: increments by 1 on each output transfer (`out_valid` && `out_ready`) with `out_sat`=1; sticks at all-ones. `cnt_clr` sets it to 0 on the next edge; clear wins over a simultaneous increment.
- No FSM beyond the two valid bits; stage state is {empty, S2 only, S1 only, both}.

## Timing
- Reset (asynchronous, `rst_n`=0): both valid bits 0, `out_valid`=0, `out_data`=0, `out_sat`=0, `sat_count`=0; `in_ready`=1 immediately after reset asserts. Reset mid-stream discards in-flight beats.
- Latency: input accepted at edge N -> `out_valid`=1 with result after edge N+1 (visible in cycle N+2 combinationally); throughput one beat/cycle with `out_ready` held high.
- `out_data`/`out_sat` stable while `out_valid`=1 and `out_ready`=0.
- Under sustained `out_ready`=0 the pipe absorbs exactly 2 beats, then `in_ready`=0; `in_ready` returns to 1 combinationally in the cycle `out_ready` rises.
- `in_ready` depends combinationally on `out_ready`; no other combinational in-to-out path.

## Test plan
- Reset, data_width=16, mode 0: in 0x0000_4000 -> 0x4000 sat=0; 0x0000_8000 -> 0x7FFF sat=1; 0xFFFF_F000 -> 0x0000 sat=0; each 2 edges after acceptance.
- Mode 1, leak_shift=3: 0xFFFF_FFC0 (-64) -> 0xFFF8 (-8) sat=0; 0x8000_0000 -> 0x8000 sat=1; 0x0001_0000 -> 0x7FFF sat=1.
- Mode 2: 0x7FFF_FFFF -> 0x7FFF sat=1; 0xFFFF_8000 -> 0x8000 sat=0; mode 3, cap=6144: 0x0000_2000 -> 0x1800 sat=1, 0x0000_1000 -> 0x1000.
- Backpressure: stream 5 beats with alternating modes, `out_ready`=0 for 4 cycles then 1 -> `in_ready` drops after 2 accepted beats, all 5 outputs emerge in order with correct per-beat mode, output held stable while stalled.
- Counter: 3 saturating beats transferred -> `sat_count`=3; `cnt_clr` in same cycle as a 4th saturating transfer -> 0; cnt_width=2 with 5 saturating beats -> sticks at 3.
- Assert `rst_n`=0 asynchronously with 2 beats in flight -> `out_valid` falls without a clock edge, no stale beat after release.
